// File: rtl/axi_synctrigger_lite_arbiter_if.sv
// ----------------------------------------------------------------------------
// axi_synctrigger_lite_arbiter_if : requester and AXI4-Lite bundle - rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface axi_synctrigger_lite_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_done;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic [1:0]                    rsp_resp;
  logic                          busy;

  logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR;
  logic [2:0]                    M_AXI_AWPROT;
  logic                          M_AXI_AWVALID;
  logic                          M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]         M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB;
  logic                          M_AXI_WVALID;
  logic                          M_AXI_WREADY;
  logic [1:0]                    M_AXI_BRESP;
  logic                          M_AXI_BVALID;
  logic                          M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR;
  logic [2:0]                    M_AXI_ARPROT;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]         M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;

  // Arbiter side: consumes requests, drives the AXI4-Lite master channels.
  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_done, rsp_rdata, rsp_resp, busy,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_done, rsp_rdata, rsp_resp, busy,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

`default_nettype wire

// File: rtl/axi_synctrigger_lite_arbiter.sv
// ----------------------------------------------------------------------------
// axi_synctrigger_lite_arbiter : round-robin AXI4-Lite register-port arbiter - rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_synctrigger_lite_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi_synctrigger_lite_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    DONE         = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d, gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d, busy_q, busy_d;
  logic [NUM_REQ-1:0]      done_q, done_d;

  logic                    found;
  logic [PTR_W-1:0]        win, cand;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  int                      sum, nxt;

  // Round-robin scan starting at the pointer, first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = PTR_W'(sum);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (PTR_W'(j) == win) begin
        sel_we    = bus.req_we[j];
        sel_addr  = bus.req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = '0;
    nxt       = int'(win) + 1;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = win;
          ptr_d   = (nxt >= NUM_REQ) ? '0 : PTR_W'(nxt);
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          busy_d  = 1'b1;
          if (sel_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        // AW and W retire independently; move on once neither is outstanding.
        if (awvalid_q && bus.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && bus.M_AXI_WREADY)   wvalid_d  = 1'b0;
        if ((!awvalid_q || bus.M_AXI_AWREADY) && (!wvalid_q || bus.M_AXI_WREADY)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.M_AXI_BVALID && bready_q) begin
          resp_d         = bus.M_AXI_BRESP;
          bready_d       = 1'b0;
          busy_d         = 1'b0;
          done_d[gnt_q]  = 1'b1;
          state_d        = DONE;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && bus.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.M_AXI_RVALID && rready_q) begin
          rdata_d        = bus.M_AXI_RDATA;
          resp_d         = bus.M_AXI_RRESP;
          rready_d       = 1'b0;
          busy_d         = 1'b0;
          done_d[gnt_q]  = 1'b1;
          state_d        = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = '1;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = bready_q;
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = rready_q;
  assign bus.req_done      = done_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_resp      = resp_q;
  assign bus.busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_synctrigger_lite_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_synctrigger_lite_arbiter : scoreboard bench with AXI4-Lite slave model - rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axi_synctrigger_lite_arbiter;
  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_synctrigger_lite_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_synctrigger_lite_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- AXI4-Lite slave model ----------------
  logic [31:0] mem [4];
  int          aw_delay = 0, w_delay = 0;
  int          aw_cnt, w_cnt;
  bit          b_hold = 1'b0, err_en = 1'b0;
  logic        aw_have, w_have;
  logic [3:0]  aw_addr_s;
  logic [31:0] w_data_s;
  int          aw_hs_cnt, w_hs_cnt;
  logic [3:0]  last_awaddr, last_wstrb;
  logic [31:0] last_wdata;
  logic        aw_hs, w_hs, aw_now, w_now;
  logic [3:0]  wr_a;
  logic [31:0] wr_d;

  assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= aw_delay);
  assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && (w_cnt >= w_delay);
  assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID;
  assign bus.M_AXI_BRESP   = 2'b00;
  assign aw_hs  = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
  assign w_hs   = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
  assign aw_now = aw_have || aw_hs;
  assign w_now  = w_have || w_hs;
  assign wr_a   = aw_have ? aw_addr_s : bus.M_AXI_AWADDR;
  assign wr_d   = w_have ? w_data_s : bus.M_AXI_WDATA;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      aw_cnt <= 0; w_cnt <= 0; aw_have <= 1'b0; w_have <= 1'b0;
      aw_addr_s <= '0; w_data_s <= '0;
      aw_hs_cnt <= 0; w_hs_cnt <= 0;
      last_awaddr <= '0; last_wstrb <= '0; last_wdata <= '0;
      bus.M_AXI_BVALID <= 1'b0;
      bus.M_AXI_RVALID <= 1'b0;
      bus.M_AXI_RDATA  <= '0;
      bus.M_AXI_RRESP  <= '0;
    end else begin
      if (aw_hs) begin
        aw_cnt <= 0; aw_hs_cnt <= aw_hs_cnt + 1; last_awaddr <= bus.M_AXI_AWADDR;
      end else if (bus.M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        w_cnt <= 0; w_hs_cnt <= w_hs_cnt + 1;
        last_wdata <= bus.M_AXI_WDATA; last_wstrb <= bus.M_AXI_WSTRB;
      end else if (bus.M_AXI_WVALID) w_cnt <= w_cnt + 1;
      if (aw_now && w_now && !b_hold && !bus.M_AXI_BVALID) begin
        bus.M_AXI_BVALID <= 1'b1;
        mem[wr_a[3:2]]   <= wr_d;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end else begin
        if (aw_hs) begin aw_have <= 1'b1; aw_addr_s <= bus.M_AXI_AWADDR; end
        if (w_hs)  begin w_have  <= 1'b1; w_data_s  <= bus.M_AXI_WDATA;  end
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) bus.M_AXI_BVALID <= 1'b0;
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        bus.M_AXI_RVALID <= 1'b1;
        bus.M_AXI_RDATA  <= mem[bus.M_AXI_ARADDR[3:2]];
        bus.M_AXI_RRESP  <= (err_en && bus.M_AXI_ARADDR == 4'h8) ? 2'b10 : 2'b00;
      end else if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) bus.M_AXI_RVALID <= 1'b0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t            e;
    logic [NR-1:0]   ev;
    forever begin
      @(negedge clk);
      if (!rst && (|bus.req_done)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: req_done=%b with nothing outstanding", bus.req_done);
        end else begin
          e = sb.pop_front();
          ev = '0;
          ev[e.idx] = 1'b1;
          chk("done_vec", 64'(bus.req_done), 64'(ev));
          chk("rsp_resp", 64'(bus.rsp_resp), 64'(e.resp));
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
        end
      end
    end
  end

  // ---------------- AXI master protocol monitor ----------------
  initial begin
    logic       p_awv, p_awr, p_wv, p_wr;
    logic [3:0] p_awaddr;
    logic [31:0] p_wdata;
    p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_awaddr = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_awv = 1'b0;
        p_wv  = 1'b0;
      end else begin
        if (p_awv && !p_awr)
          chk("awvalid_hold", 64'({bus.M_AXI_AWVALID, bus.M_AXI_AWADDR}), 64'({1'b1, p_awaddr}));
        if (p_awv && p_awr) chk("awvalid_drop", 64'(bus.M_AXI_AWVALID), 64'(0));
        if (p_wv && !p_wr)
          chk("wvalid_hold", 64'({bus.M_AXI_WVALID, bus.M_AXI_WDATA}), 64'({1'b1, p_wdata}));
        if (p_wv && p_wr) chk("wvalid_drop", 64'(bus.M_AXI_WVALID), 64'(0));
        if (bus.M_AXI_BREADY)
          chk("bready_after_aw_w", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID}), 64'(0));
        p_awv = bus.M_AXI_AWVALID; p_awr = bus.M_AXI_AWREADY; p_awaddr = bus.M_AXI_AWADDR;
        p_wv  = bus.M_AXI_WVALID;  p_wr  = bus.M_AXI_WREADY;  p_wdata  = bus.M_AXI_WDATA;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] last_rd = '0;

  task automatic push(input int idx, input logic [31:0] rdata, input logic [1:0] resp);
    exp_t e;
    e.idx = idx; e.rdata = rdata; e.resp = resp;
    sb.push_back(e);
  endtask

  // Holds the masked requests until 'total' completions; called at a negedge.
  task automatic run(input logic [NR-1:0] mask, input int total, input bit drop, output int lat);
    int seen = 0;
    int cyc  = 0;
    lat = 0;
    bus.req_valid = mask;
    while (seen < total && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (|bus.req_done) begin
        seen++;
        lat = cyc;
        if (drop) bus.req_valid = bus.req_valid & ~bus.req_done;
        if (seen == total) bus.req_valid = '0;
      end
    end
    n_checks++;
    if (seen < total) begin
      n_fail++;
      $display("FAIL run_timeout: saw %0d of %0d completions", seen, total);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  // For writes 'data' is the write data; for reads it is the expected read data.
  task automatic xact(input int idx, input bit we, input logic [3:0] addr,
                      input logic [31:0] data, input logic [1:0] resp, output int lat);
    bus.req_we[idx] = we;
    bus.req_addr[idx*AW +: AW] = addr;
    bus.req_wdata[idx*DW +: DW] = we ? data : 32'h0;
    if (!we) last_rd = data;
    push(idx, last_rd, resp);
    run(NR'(1) << idx, 1, 1'b1, lat);
  endtask

  initial begin
    int lat;
    int k;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_ready", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                  bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 64'(0));
    chk("reset_busy_done", 64'({bus.busy, bus.req_done}), 64'(0));
    chk("reset_rsp", 64'({bus.rsp_rdata, bus.rsp_resp}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single write by requester 0
    xact(0, 1'b1, 4'h4, 32'h2, 2'b00, lat);
    chk("write_latency_cycles", 64'(lat + 1), 64'(4));
    chk("aw_handshakes", 64'(aw_hs_cnt), 64'(1));
    chk("w_handshakes", 64'(w_hs_cnt), 64'(1));
    chk("awaddr", 64'(last_awaddr), 64'(4'h4));
    chk("wdata", 64'(last_wdata), 64'(32'h2));
    chk("wstrb", 64'(last_wstrb), 64'(4'hF));

    // Fill and read back the register space from requester 1
    for (k = 0; k < 4; k++) xact(1, 1'b1, 4'(4 * k), 32'(k + 1), 2'b00, lat);
    for (k = 0; k < 4; k++) begin
      xact(1, 1'b0, 4'(4 * k), 32'(k + 1), 2'b00, lat);
      if (k == 0) chk("read_latency_cycles", 64'(lat + 1), 64'(4));
    end

    // Both requesting continuously: grants 0,1,0,1
    bus.req_we = '0;
    bus.req_addr[0 +: AW]  = 4'h0;
    bus.req_addr[AW +: AW] = 4'h4;
    push(0, 32'h1, 2'b00);
    push(1, 32'h2, 2'b00);
    push(0, 32'h1, 2'b00);
    push(1, 32'h2, 2'b00);
    last_rd = 32'h2;
    run(2'b11, 4, 1'b0, lat);

    // AW delayed three cycles, then W delayed three cycles
    aw_delay = 3;
    xact(0, 1'b1, 4'h8, 32'hA5, 2'b00, lat);
    chk("aw_delayed_latency", 64'(lat), 64'(6));
    aw_delay = 0;
    w_delay  = 3;
    xact(1, 1'b1, 4'hC, 32'h5A, 2'b00, lat);
    chk("w_delayed_latency", 64'(lat), 64'(6));
    w_delay = 0;
    chk("aw_handshakes_total", 64'(aw_hs_cnt), 64'(7));

    // SLVERR passes through, next read is normal
    err_en = 1'b1;
    xact(0, 1'b0, 4'h8, 32'hA5, 2'b10, lat);
    xact(1, 1'b0, 4'hC, 32'h5A, 2'b00, lat);
    err_en = 1'b0;

    // Reset while waiting on the write response
    b_hold = 1'b1;
    bus.req_we[0] = 1'b1;
    bus.req_addr[0 +: AW] = 4'h0;
    bus.req_wdata[0 +: DW] = 32'h9;
    bus.req_valid = 2'b01;
    k = 0;
    while (!bus.M_AXI_BREADY && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reached_wr_resp", 64'(bus.M_AXI_BREADY), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("midreset_valid_ready", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                     bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 64'(0));
    chk("midreset_busy_done", 64'({bus.busy, bus.req_done}), 64'(0));
    bus.req_valid = '0;
    b_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    repeat (3) @(negedge clk);

    // First grant after reset goes to requester 0
    bus.req_we = 2'b11;
    bus.req_addr[0 +: AW]   = 4'h0;
    bus.req_addr[AW +: AW]  = 4'h4;
    bus.req_wdata[0 +: DW]  = 32'h11;
    bus.req_wdata[DW +: DW] = 32'h22;
    push(0, 32'h0, 2'b00);
    push(1, 32'h0, 2'b00);
    run(2'b11, 2, 1'b1, lat);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
